acondicionador_temp: RTL and testbench
======================================

ACONDICIONADOR_TEMP -- requirements
Module: acondicionador_temp

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port srst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port muestra_valida, input, 1, raw sensor sample strobe; one sample per high cycle.
REQ-004 SHALL have port muestra_dato, input, 10, raw sample, unsigned, tenths of degC (220 = 22.0 degC).
REQ-005 SHALL have port temp_salida, output, 10, filtered temperature, registered; drives monitoreo_top temp_entrada.
REQ-006 SHALL have port temp_valida, output, 1, one-cycle pulse when temp_salida updates.
REQ-007 SHALL have port falla_sensor, output, 1, high while in FALLA.
REQ-008 SHALL have port estado_filtro, output, 2, state: 00 LLENANDO, 01 FILTRANDO, 10 FALLA.
REQ-009 SHALL have port contador_fallas, output, 8, count of FALLA entries, saturating at 255.

Function
REQ-010 SHALL accept a sample only when muestra_valida=1.
REQ-011 SHALL classify a sample as good iff TEMP_SENS_MIN (50) <= muestra_dato <= TEMP_SENS_MAX (600), bounds inclusive.
REQ-012 SHALL write good samples only into a 4-entry window; bad samples never enter it.
REQ-013 SHALL compute the average as (sum of 4 entries, 12-bit, no overflow) >> 2, truncating.
REQ-014 SHALL have LLENANDO count good samples 0..3; the 4th good sample moves the FSM to FILTRANDO.
REQ-015 SHALL, on each good sample that leaves or keeps the FSM in FILTRANDO, load temp_salida with the window average including that sample, and pulse temp_valida, one cycle after acceptance.
REQ-016 SHALL keep temp_valida low and temp_salida at 220 in LLENANDO.
REQ-017 SHALL, on a bad sample in LLENANDO or FILTRANDO, go to FALLA next cycle, set falla_sensor=1 and increment contador_fallas (saturating).
REQ-018 SHALL hold temp_salida at its last value in FALLA, with no temp_valida pulse.
REQ-019 SHALL have FALLA count consecutive good samples; a bad sample clears the count; the 4th consecutive good sample goes to FILTRANDO with a temp_valida pulse (window then holds only those 4).
REQ-020 SHALL ignore a bad sample in FALLA apart from the count clear; no further contador_fallas increment.
REQ-021 SHALL have no other transitions; the encoding value 11 is unreachable and SHALL go to LLENANDO.

Reset
REQ-022 SHALL, with srst=1, set next edge: estado_filtro=00, temp_salida=220, temp_valida=0, falla_sensor=0, contador_fallas=0, window and all counters 0.
REQ-023 SHALL give srst priority over muestra_valida in the same cycle; that sample is discarded.

Configuration
REQ-024 SHALL, with STUCK_DETECT_EN defined, treat a good sample as bad when it is the 16th consecutive accepted sample with identical value (run counter cleared by a differing sample or by reset).
REQ-025 SHALL, with STUCK_DETECT_EN undefined, omit the stuck-value logic; identical samples are filtered normally.

Structure
REQ-026 SHALL take TEMP_SENS_MIN, TEMP_SENS_MAX, TEMP_RESET_VAL (220), VENTANA_N (4), STUCK_N (16) and an estado_filtro_t enum from monitoreo_pkg.
REQ-027 SHALL put the window shift register and running sum in sub-module ventana_promedio (inputs wr_en, dato, clr; output promedio).

Verification
REQ-028 SHALL cover: reset, then samples 200,220,240,260 -> no valid on first three; after 260 temp_valida pulse, temp_salida=230, estado_filtro=01.
REQ-029 SHALL cover: in FILTRANDO, sample 700 -> next cycle falla_sensor=1, estado_filtro=10, contador_fallas=1, temp_salida stays 230.
REQ-030 SHALL cover: in FALLA, samples 250,250,250,30,250,250,250,250 -> stays FALLA until the last 250, then estado_filtro=01, temp_salida=250, one valid pulse.
REQ-031 SHALL cover: boundaries 50 and 600 accepted; 49 and 601 enter FALLA; four 600s -> temp_salida=600.
REQ-032 SHALL cover: 16 samples of 221 -> with STUCK_DETECT_EN, FALLA on the 16th; without it, valid pulses with temp_salida=221 throughout.
REQ-033 SHALL cover: srst=1 with muestra_valida=1 during FILTRANDO -> next edge estado_filtro=00, temp_salida=220, contador_fallas=0, sample discarded.

Source files
------------

// File: rtl/monitoreo_pkg.sv
// rtl/monitoreo_pkg.sv - shared constants, filter state type and sample classifier
package monitoreo_pkg;

   localparam logic [9:0] TEMP_SENS_MIN  = 10'd50;
   localparam logic [9:0] TEMP_SENS_MAX  = 10'd600;
   localparam logic [9:0] TEMP_RESET_VAL = 10'd220;
   localparam int         VENTANA_N      = 4;
   localparam int         STUCK_N        = 16;

   typedef enum logic [1:0] {
      LLENANDO  = 2'b00,
      FILTRANDO = 2'b01,
      FALLA     = 2'b10
   } estado_filtro_t;

   // In-range check on a raw sample, both bounds inclusive
   function automatic logic es_buena(input logic [9:0] dato);
      return (dato >= TEMP_SENS_MIN) && (dato <= TEMP_SENS_MAX);
   endfunction

endpackage

// File: rtl/ventana_promedio.sv
// rtl/ventana_promedio.sv - 4-entry sample window with running sum and average
module ventana_promedio
   import monitoreo_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       wr_en,
   input  logic [9:0] dato,
   output logic [9:0] promedio
);

   logic [9:0]  win_q [VENTANA_N];
   logic [9:0]  win_d [VENTANA_N];
   logic [11:0] sum_q;
   logic [11:0] sum_d;

   // Shift the new sample in and adjust the sum by entering minus leaving entry
   always_comb begin
      win_d = win_q;
      sum_d = sum_q;
      if (wr_en) begin
         for (int i = VENTANA_N - 1; i > 0; i--) begin
            win_d[i] = win_q[i-1];
         end
         win_d[0] = dato;
         sum_d    = sum_q - {2'b00, win_q[VENTANA_N-1]} + {2'b00, dato};
      end
   end

   // Average of the window including a sample being written this cycle,
   // so the caller can register it on the same edge that accepts the sample
   assign promedio = sum_d[11:2];

   // Window and sum registers, cleared synchronously
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < VENTANA_N; i++) begin
            win_q[i] <= '0;
         end
         sum_q <= '0;
      end else begin
         win_q <= win_d;
         sum_q <= sum_d;
      end
   end

endmodule

// File: rtl/acondicionador_temp.sv
// rtl/acondicionador_temp.sv - temperature sample conditioner; optional STUCK_DETECT_EN
module acondicionador_temp
   import monitoreo_pkg::*;
(
   input  logic       clk,
   input  logic       srst,
   input  logic       muestra_valida,
   input  logic [9:0] muestra_dato,
   output logic [9:0] temp_salida,
   output logic       temp_valida,
   output logic       falla_sensor,
   output logic [1:0] estado_filtro,
   output logic [7:0] contador_fallas
);

   estado_filtro_t state_q, state_d;
   logic [1:0]     cnt_q, cnt_d;
   logic [9:0]     temp_q, temp_d;
   logic           valid_q, valid_d;
   logic [7:0]     fallas_q, fallas_d;
   logic           wr_en;
   logic           stuck;
   logic           buena;
   logic           mala;
   logic [9:0]     promedio;

`ifdef STUCK_DETECT_EN
   logic [9:0] last_q, last_d;
   logic [4:0] run_q, run_d;

   // Track the length of the current run of identical accepted samples
   always_comb begin
      last_d = last_q;
      run_d  = run_q;
      stuck  = 1'b0;
      if (muestra_valida) begin
         last_d = muestra_dato;
         if ((run_q != 5'd0) && (muestra_dato == last_q)) begin
            run_d = (run_q == 5'd31) ? run_q : run_q + 5'd1;
            stuck = (run_q >= 5'(STUCK_N - 1));
         end else begin
            run_d = 5'd1;
         end
      end
   end

   // Run tracker registers
   always_ff @(posedge clk) begin
      if (srst) begin
         last_q <= '0;
         run_q  <= '0;
      end else begin
         last_q <= last_d;
         run_q  <= run_d;
      end
   end
`else
   assign stuck = 1'b0;
`endif

   assign buena = muestra_valida && es_buena(muestra_dato) && !stuck;
   assign mala  = muestra_valida && !buena;

   // Next state, window write enable and output updates
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      temp_d   = temp_q;
      valid_d  = 1'b0;
      fallas_d = fallas_q;
      wr_en    = 1'b0;
      case (state_q)
         LLENANDO: begin
            if (buena) begin
               wr_en = 1'b1;
               if (cnt_q == 2'd3) begin
                  state_d = FILTRANDO;
                  cnt_d   = 2'd0;
                  temp_d  = promedio;
                  valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (mala) begin
               state_d  = FALLA;
               cnt_d    = 2'd0;
               fallas_d = (fallas_q == 8'hFF) ? fallas_q : fallas_q + 8'd1;
            end
         end
         FILTRANDO: begin
            if (buena) begin
               wr_en   = 1'b1;
               temp_d  = promedio;
               valid_d = 1'b1;
            end else if (mala) begin
               state_d  = FALLA;
               cnt_d    = 2'd0;
               fallas_d = (fallas_q == 8'hFF) ? fallas_q : fallas_q + 8'd1;
            end
         end
         FALLA: begin
            // Good samples still enter the window, so after four in a row
            // the window holds exactly that run
            if (buena) begin
               wr_en = 1'b1;
               if (cnt_q == 2'd3) begin
                  state_d = FILTRANDO;
                  cnt_d   = 2'd0;
                  temp_d  = promedio;
                  valid_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end else if (mala) begin
               cnt_d = 2'd0;
            end
         end
         default: begin
            state_d = LLENANDO;
            cnt_d   = 2'd0;
         end
      endcase
   end

   // State and output registers; reset wins over any sample in the same cycle
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q  <= LLENANDO;
         cnt_q    <= '0;
         temp_q   <= TEMP_RESET_VAL;
         valid_q  <= 1'b0;
         fallas_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         temp_q   <= temp_d;
         valid_q  <= valid_d;
         fallas_q <= fallas_d;
      end
   end

   ventana_promedio u_ventana (
      .clk      (clk),
      .clr      (srst),
      .wr_en    (wr_en && !srst),
      .dato     (muestra_dato),
      .promedio (promedio)
   );

   assign temp_salida     = temp_q;
   assign temp_valida     = valid_q;
   assign falla_sensor    = (state_q == FALLA);
   assign estado_filtro   = state_q;
   assign contador_fallas = fallas_q;

endmodule

// File: tb/tb_acondicionador_temp.sv
// tb/tb_acondicionador_temp.sv - self-checking bench for acondicionador_temp
module tb_acondicionador_temp;

   logic       clk;
   logic       srst;
   logic       muestra_valida;
   logic [9:0] muestra_dato;
   logic [9:0] temp_salida;
   logic       temp_valida;
   logic       falla_sensor;
   logic [1:0] estado_filtro;
   logic [7:0] contador_fallas;

   int n_tests = 0;
   int n_fail  = 0;

   // model of expected outputs after the coming edge
   int m_mode;      // 0 filling, 1 filtering, 2 fault
   int m_goods;     // good samples counted toward leaving filling/fault
   int m_temp;
   int m_valid;
   int m_fallas;
   int m_last;
   int m_run;
   int win[$];
   bit chk_en = 0;

   acondicionador_temp dut (
      .clk             (clk),
      .srst            (srst),
      .muestra_valida  (muestra_valida),
      .muestra_dato    (muestra_dato),
      .temp_salida     (temp_salida),
      .temp_valida     (temp_valida),
      .falla_sensor    (falla_sensor),
      .estado_filtro   (estado_filtro),
      .contador_fallas (contador_fallas)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit v, input int d);
      bit good;
      int sum;
      m_valid = 0;
      if (r) begin
         m_mode = 0; m_goods = 0; m_temp = 220; m_fallas = 0;
         m_last = 0; m_run = 0;
         win.delete();
         chk_en = 1;
      end else if (v) begin
         if (m_run > 0 && d == m_last) m_run++;
         else m_run = 1;
         m_last = d;
         good = (d >= 50) && (d <= 600);
`ifdef STUCK_DETECT_EN
         if (m_run >= 16) good = 0;
`endif
         if (good) begin
            win.push_back(d);
            if (win.size() > 4) void'(win.pop_front());
            if (m_mode != 1) m_goods++;
            if (m_mode == 1 || m_goods == 4) begin
               sum = 0;
               foreach (win[i]) sum += win[i];
               m_temp  = sum / 4;
               m_valid = 1;
               m_mode  = 1;
               m_goods = 0;
            end
         end else begin
            if (m_mode != 2) begin
               m_mode = 2;
               if (m_fallas < 255) m_fallas++;
            end
            m_goods = 0;
         end
      end
   endtask

   // one clock: drive inputs at the falling edge, then settle past the rising edge
   task automatic cyc(input bit r, input bit v, input int d);
      @(negedge clk);
      srst = r; muestra_valida = v; muestra_dato = 10'(d);
      model_step(r, v, d);
      @(posedge clk);
      #2;
   endtask

   // every-cycle comparison against the model
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         chk("temp_salida", int'(temp_salida), m_temp);
         chk("temp_valida", int'(temp_valida), m_valid);
         chk("falla_sensor", int'(falla_sensor), (m_mode == 2) ? 1 : 0);
         chk("estado_filtro", int'(estado_filtro), m_mode);
         chk("contador_fallas", int'(contador_fallas), m_fallas);
      end
   end

   initial begin
      srst = 1; muestra_valida = 0; muestra_dato = 0;

      cyc(1, 0, 0);
      cyc(1, 0, 0);
      chk("rst_estado", int'(estado_filtro), 0);
      chk("rst_temp", int'(temp_salida), 220);
      chk("rst_fallas", int'(contador_fallas), 0);
      chk("rst_valid", int'(temp_valida), 0);

      // filling
      cyc(0, 1, 200); chk("fill1_valid", int'(temp_valida), 0);
      cyc(0, 1, 220); chk("fill2_valid", int'(temp_valida), 0);
      cyc(0, 1, 240); chk("fill3_valid", int'(temp_valida), 0);
      chk("fill3_temp", int'(temp_salida), 220);
      cyc(0, 1, 260);
      chk("fill4_valid", int'(temp_valida), 1);
      chk("fill4_temp", int'(temp_salida), 230);
      chk("fill4_estado", int'(estado_filtro), 1);
      cyc(0, 0, 0);
      chk("idle_valid", int'(temp_valida), 0);

      // out-of-range sample in filtering
      cyc(0, 1, 700);
      chk("bad700_falla", int'(falla_sensor), 1);
      chk("bad700_estado", int'(estado_filtro), 2);
      chk("bad700_fallas", int'(contador_fallas), 1);
      chk("bad700_temp", int'(temp_salida), 230);

      // recovery with an interrupting bad sample
      cyc(0, 1, 250); cyc(0, 1, 250); cyc(0, 1, 250);
      cyc(0, 1, 30);
      chk("rec_bad_estado", int'(estado_filtro), 2);
      chk("rec_bad_fallas", int'(contador_fallas), 1);
      cyc(0, 1, 250); cyc(0, 1, 250); cyc(0, 1, 250);
      chk("rec3_estado", int'(estado_filtro), 2);
      chk("rec3_valid", int'(temp_valida), 0);
      cyc(0, 1, 250);
      chk("rec4_estado", int'(estado_filtro), 1);
      chk("rec4_temp", int'(temp_salida), 250);
      chk("rec4_valid", int'(temp_valida), 1);
      cyc(0, 0, 0);

      // boundaries
      cyc(0, 1, 50);  chk("b50_temp", int'(temp_salida), 200);
      cyc(0, 1, 600); chk("b600_temp", int'(temp_salida), 287);
      cyc(0, 1, 49);
      chk("b49_estado", int'(estado_filtro), 2);
      chk("b49_fallas", int'(contador_fallas), 2);
      for (int i = 0; i < 4; i++) cyc(0, 1, 600);
      chk("b600x4_temp", int'(temp_salida), 600);
      chk("b600x4_estado", int'(estado_filtro), 1);
      cyc(0, 1, 601);
      chk("b601_estado", int'(estado_filtro), 2);
      chk("b601_fallas", int'(contador_fallas), 3);
      for (int i = 0; i < 4; i++) cyc(0, 1, 600);
      chk("b601rec_temp", int'(temp_salida), 600);

      // sixteen identical samples
      for (int i = 0; i < 16; i++) begin
         cyc(0, 1, 221);
         if (i == 0) chk("s221_first_temp", int'(temp_salida), 505);
      end
`ifdef STUCK_DETECT_EN
      chk("s221_estado", int'(estado_filtro), 2);
      chk("s221_fallas", int'(contador_fallas), 4);
`else
      chk("s221_estado", int'(estado_filtro), 1);
      chk("s221_temp", int'(temp_salida), 221);
      chk("s221_valid", int'(temp_valida), 1);
`endif

      // reset with a simultaneous sample
      cyc(1, 1, 300);
      chk("rsv_estado", int'(estado_filtro), 0);
      chk("rsv_temp", int'(temp_salida), 220);
      chk("rsv_fallas", int'(contador_fallas), 0);
      cyc(0, 1, 100); cyc(0, 1, 100); cyc(0, 1, 100);
      chk("rsv3_estado", int'(estado_filtro), 0);
      cyc(0, 1, 104);
      chk("rsv4_estado", int'(estado_filtro), 1);
      chk("rsv4_temp", int'(temp_salida), 101);
      cyc(0, 0, 0);
      cyc(0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
